pixel_scanout: RTL and testbench



---
 rtl/pixel_scanout.sv | 170 +++++++++++++++++
 tb/tb_pixel_scanout.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanout.sv
// Streams a NUM_ROWS x ROW_W 1-bit bitmap in raster order; start->first pixel 3 cycles, pix_ready stalls hold all pixel outputs.
// SCANOUT_PREFETCH_EN: shadow row buffer fetches row y+1 during row y, removing the 2-cycle FETCH/WAIT bubble per row.
module pixel_scanout #(
  parameter int ROW_W    = 64,
  parameter int NUM_ROWS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        rd_en,
  output logic [$clog2(NUM_ROWS)-1:0] rd_addr,
  input  logic [ROW_W-1:0]            rd_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        pix_value,
  output logic [$clog2(ROW_W)-1:0]    pix_x,
  output logic [$clog2(NUM_ROWS)-1:0] pix_y,
  output logic                        pix_last,
  output logic                        busy,
  output logic                        done
);

  localparam int XW = $clog2(ROW_W);
  localparam int YW = $clog2(NUM_ROWS);
  localparam logic [XW-1:0] LAST_X = XW'(ROW_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [ROW_W-1:0] row_buf_q, row_buf_d;
  logic             rd_en_q, rd_en_d;
  logic [YW-1:0]    rd_addr_q, rd_addr_d;
  logic             xfer;
  logic [YW-1:0]    y_next;

`ifdef SCANOUT_PREFETCH_EN
  logic [ROW_W-1:0] shadow_q, shadow_d;
  logic             shadow_vld_q, shadow_vld_d;
  logic             rd_pend_q, rd_pend_d;
`endif

  assign xfer   = (state_q == S_STREAM) && pix_ready;
  assign y_next = y_q + YW'(1);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    row_buf_d = row_buf_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
`ifdef SCANOUT_PREFETCH_EN
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    rd_pend_d    = rd_en_q;
    // A prefetch read lands while streaming; reads issued from FETCH land in WAIT instead.
    if (rd_pend_q && (state_q == S_STREAM)) begin
      shadow_d     = rd_data;
      shadow_vld_d = 1'b1;
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        row_buf_d = rd_data;
        state_d   = S_STREAM;
`ifdef SCANOUT_PREFETCH_EN
        if (y_q != LAST_Y) begin
          rd_en_d   = 1'b1;
          rd_addr_d = y_next;
        end
`endif
      end
      S_STREAM: begin
        if (xfer) begin
          if (x_q == LAST_X) begin
            x_d = '0;
            if (y_q == LAST_Y) begin
              state_d   = S_DONE;
              y_d       = '0;
              rd_addr_d = '0;
            end else begin
              y_d = y_next;
`ifdef SCANOUT_PREFETCH_EN
              if (shadow_vld_q) begin
                row_buf_d    = shadow_q;
                shadow_vld_d = 1'b0;
                if (y_next != LAST_Y) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = y_q + YW'(2);
                end
              end else begin
                state_d   = S_FETCH;
                rd_en_d   = 1'b1;
                rd_addr_d = y_next;
              end
`else
              state_d   = S_FETCH;
              rd_en_d   = 1'b1;
              rd_addr_d = y_next;
`endif
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      row_buf_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
`ifdef SCANOUT_PREFETCH_EN
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      rd_pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_buf_q <= row_buf_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
`ifdef SCANOUT_PREFETCH_EN
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      rd_pend_q    <= rd_pend_d;
`endif
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign pix_valid = (state_q == S_STREAM);
  assign pix_value = row_buf_q[x_q];
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_last  = pix_valid && (x_q == LAST_X) && (y_q == LAST_Y);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout: frame-buffer model, per-pixel scoreboard, start/reset/bubble directed cases.
module tb_pixel_scanout;

`ifdef SCANOUT_PREFETCH_EN
  localparam int EXP_LAST = 4098;
  localparam int EXP_BUB  = 0;
`else
  localparam int EXP_LAST = 4224;
  localparam int EXP_BUB  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic        pix_valid, pix_value, pix_last, busy, done;
  logic [5:0]  pix_x, pix_y;

  pixel_scanout dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_value(pix_value),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency, garbage on the bus when not reading.
  logic [63:0] mem [64];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {$urandom, $urandom};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       v;
    logic       l;
  } pix_t;

  pix_t exp_q[$];
  pix_t exp_e, got_e;

  int checks = 0;
  int errors = 0;
  int xfer_cnt, done_cnt, rd_en_cnt, bubbles, last_cyc, t0;
  bit row0_end;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_done = 1'b0;
  logic [14:0] prev_snap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, done/busy sequencing, row-0 bubble count.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        chk("stall_hold", 64'({pix_valid, pix_x, pix_y, pix_value, pix_last}), 64'(prev_snap));
      if (prev_done)
        chk("busy_after_done", 64'(busy), 64'd0);
      if (rd_en) rd_en_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_cyc + 1));
      end
      if (row0_end) begin
        if (pix_valid) row0_end = 1'b0;
        else bubbles++;
      end
      if (pix_valid && pix_ready) begin
        xfer_cnt++;
        chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          got_e = '{x: pix_x, y: pix_y, v: pix_value, l: pix_last};
          chk("pixel", 64'(got_e), 64'(exp_e));
        end
        if (pix_last) last_cyc = cyc;
        if (pix_x == 6'd63 && pix_y == 6'd0) row0_end = 1'b1;
      end
    end
    prev_stall = !rst && pix_valid && !pix_ready;
    prev_snap  = {pix_valid, pix_x, pix_y, pix_value, pix_last};
    prev_done  = !rst && done;
  end

  task automatic start_frame;
    exp_q.delete();
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++)
        exp_q.push_back('{x: 6'(xx), y: 6'(yy), v: mem[yy][xx], l: (xx == 63 && yy == 63)});
    xfer_cnt  = 0;
    done_cnt  = 0;
    rd_en_cnt = 0;
    bubbles   = 0;
    row0_end  = 1'b0;
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 20000 && !done; i++) tick();
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},     64'(rd_en),     64'd0);
    chk({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
    chk({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
    chk({tag, "_pix_value"}, 64'(pix_value), 64'd0);
    chk({tag, "_pix_x"},     64'(pix_x),     64'd0);
    chk({tag, "_pix_y"},     64'(pix_y),     64'd0);
    chk({tag, "_pix_last"},  64'(pix_last),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  task automatic check_frame_totals(input string tag);
    chk({tag, "_xfers"},     64'(xfer_cnt),     64'd4096);
    chk({tag, "_done_cnt"},  64'(done_cnt),     64'd1);
    chk({tag, "_rd_en_cnt"}, 64'(rd_en_cnt),    64'd64);
    chk({tag, "_leftover"},  64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Frame 1: diagonal bitmap, full rate, start latency and bubble count
    for (int y = 0; y < 64; y++) mem[y] = 64'd1 << y;
    start_frame();
    chk("t1_rd_en",   64'(rd_en),   64'd1);
    chk("t1_rd_addr", 64'(rd_addr), 64'd0);
    chk("t1_busy",    64'(busy),    64'd1);
    tick();
    chk("t2_pix_valid", 64'(pix_valid), 64'd0);
    tick();
    chk("t3_pix_valid", 64'(pix_valid), 64'd1);
    chk("t3_pix_xy",    64'({pix_x, pix_y}), 64'd0);
    wait_done();
    tick();
    tick();
    check_frame_totals("diag");
    chk("diag_last_time", 64'(last_cyc - t0), 64'(EXP_LAST));
    chk("row_bubbles",    64'(bubbles),       64'(EXP_BUB));

    // Frame 2: random stalls, row 5 blank, start mid-frame and in DONE
    for (int y = 0; y < 64; y++) mem[y] = '1;
    mem[5] = '0;
    rand_rdy = 1'b1;
    start_frame();
    for (int i = 0; i < 5000 && !(pix_valid && pix_x == 6'd10 && pix_y == 6'd2); i++) tick();
    chk("reach_10_2", 64'(pix_valid && pix_x == 6'd10 && pix_y == 6'd2), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_busy",  64'(busy),  64'd0);
    chk("done_start_rd_en", 64'(rd_en), 64'd0);
    tick();
    chk("idle_busy",  64'(busy),  64'd0);
    chk("idle_rd_en", 64'(rd_en), 64'd0);
    check_frame_totals("stall");
    rand_rdy = 1'b0;
    tick();

    // Frame 3: reset at (30,7); frame 4 must read fresh data from (0,0)
    for (int y = 0; y < 64; y++) mem[y] = ~(64'd1 << y);
    start_frame();
    for (int i = 0; i < 5000 && !(pix_valid && pix_x == 6'd30 && pix_y == 6'd7); i++) tick();
    chk("reach_30_7", 64'(pix_valid && pix_x == 6'd30 && pix_y == 6'd7), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    for (int y = 0; y < 64; y++) mem[y] = 64'h0123_4567_89AB_CDEF ^ 64'(y);
    tick();
    start_frame();
    wait_done();
    tick();
    tick();
    check_frame_totals("fresh");
    chk("fresh_last_time", 64'(last_cyc - t0), 64'(EXP_LAST));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
